// File: rtl/axi_read_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_slave
//  Description : AXI read-channel slave. Accepts one AR burst at a time,
//                streams word reads from a 1-cycle-latency memory into a
//                2-entry output FIFO and returns the beats on the R channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_read_slave #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_AW     = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   arid_s_inf,
    input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
    input  logic [7:0]            arlen_s_inf,
    input  logic [2:0]            arsize_s_inf,
    input  logic [1:0]            arburst_s_inf,
    input  logic                  arvalid_s_inf,
    output logic                  arready_s_inf,
    output logic [ID_WIDTH-1:0]   rid_s_inf,
    output logic [DATA_WIDTH-1:0] rdata_s_inf,
    output logic [1:0]            rresp_s_inf,
    output logic                  rlast_s_inf,
    output logic                  rvalid_s_inf,
    input  logic                  rready_s_inf,
    output logic                  mem_en,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic                  fixed_q, fixed_d;
    logic [MEM_AW-1:0]     ptr_q, ptr_d;
    // 9 bits so that a 256-beat burst can count all the way to 256 issued reads
    logic [8:0]            issue_cnt_q, issue_cnt_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  w_ar_hs;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_last_beat;
    logic [2:0]            w_occ;
    logic                  w_unused;

    // Transfer size and the byte/upper address bits play no part in word addressing
    assign w_unused = ^{arsize_s_inf, araddr_s_inf[ADDR_WIDTH-1:MEM_AW+1], araddr_s_inf[0]};

    assign arready_s_inf = (state_q == S_IDLE);
    assign rvalid_s_inf  = (count_q != 2'd0);
    assign rdata_s_inf   = fifo_q[rd_ptr_q];
    assign rid_s_inf     = id_q;
    assign rresp_s_inf   = 2'b00;
    assign w_last_beat   = (beat_cnt_q == len_q);
    assign rlast_s_inf   = rvalid_s_inf & w_last_beat;
    assign mem_en        = w_issue;
    assign mem_addr      = ptr_q;

    assign w_ar_hs = arvalid_s_inf & arready_s_inf;
    assign w_pop   = rvalid_s_inf & rready_s_inf;
    // Memory data arrives exactly one cycle after its strobe
    assign w_push  = inflight_q;

    // Slots that will be committed after this edge; issue only if one stays free
    assign w_occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_issue = (state_q == S_BURST)
                   && (issue_cnt_q <= {1'b0, len_q})
                   && (w_occ < 3'd2);

    // Next-state computation for the FSM, address/count tracking and the FIFO
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        len_d       = len_q;
        fixed_d     = fixed_q;
        ptr_d       = ptr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        inflight_d  = w_issue;
        fifo_d[0]   = fifo_q[0];
        fifo_d[1]   = fifo_q[1];
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + {1'b0, w_push} - {1'b0, w_pop};

        if (w_ar_hs) begin
            state_d     = S_BURST;
            id_d        = arid_s_inf;
            len_d       = arlen_s_inf;
            fixed_d     = (arburst_s_inf == 2'b00);
            ptr_d       = araddr_s_inf[MEM_AW:1];
            issue_cnt_d = 9'd0;
            beat_cnt_d  = 8'd0;
        end

        if (w_issue) begin
            issue_cnt_d = issue_cnt_q + 9'd1;
            if (!fixed_q) begin
                // Natural wrap modulo 2^MEM_AW
                ptr_d = ptr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
            end
        end

        if (w_push) begin
            fifo_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (w_pop) begin
            rd_ptr_d   = ~rd_ptr_q;
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (w_last_beat) begin
                state_d = S_IDLE;
            end
        end
    end

    // All state registers; reset abandons any burst and its in-flight read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            len_q       <= '0;
            fixed_q     <= 1'b0;
            ptr_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            len_q       <= len_d;
            fixed_q     <= fixed_d;
            ptr_q       <= ptr_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= inflight_d;
            fifo_q[0]   <= fifo_d[0];
            fifo_q[1]   <= fifo_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_read_slave
//  Description : Directed self-checking bench for axi_read_slave with an
//                address/beat scoreboard and a 1-cycle-latency memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_slave;

    logic        clk;
    logic        rst_n;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [15:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    logic [15:0] mem [4096];
    logic [11:0] exp_addr_q [$];
    beat_t       exp_beat_q [$];

    int checks = 0;
    int errors = 0;

    axi_read_slave dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arid_s_inf    (arid),
        .araddr_s_inf  (araddr),
        .arlen_s_inf   (arlen),
        .arsize_s_inf  (arsize),
        .arburst_s_inf (arburst),
        .arvalid_s_inf (arvalid),
        .arready_s_inf (arready),
        .rid_s_inf     (rid),
        .rdata_s_inf   (rdata),
        .rresp_s_inf   (rresp),
        .rlast_s_inf   (rlast),
        .rvalid_s_inf  (rvalid),
        .rready_s_inf  (rready),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data valid the cycle after the strobe
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [3:0] id, input logic [11:0] word,
                              input logic [7:0] len, input bit fixed);
        logic [11:0] a;
        beat_t b;
        for (int i = 0; i <= int'(len); i++) begin
            a = fixed ? word : word + 12'(i);
            exp_addr_q.push_back(a);
            b.data = mem[a];
            b.id   = id;
            b.last = (i == int'(len));
            exp_beat_q.push_back(b);
        end
    endtask

    // Drive an AR request; returns in the cycle after the handshake
    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit hold);
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arburst = burst;
        arsize  = 3'd1;
        arvalid = 1'b1;
        chk("ar_ready", {31'd0, arready}, 32'd1);
        push_burst(id, addr[12:1], len, burst == 2'b00);
        tick();
        if (!hold) arvalid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int i;
        i = 0;
        while (i < bound && (exp_beat_q.size() != 0 || !arready)) begin
            tick();
            i++;
        end
        chk("drain", {29'd0, exp_beat_q.size() == 0, exp_addr_q.size() == 0, arready}, 32'd7);
    endtask

    // Scoreboard / protocol monitor, sampled mid-cycle
    int    issued    = 0;
    int    delivered = 0;
    bit    stall_v   = 1'b0;
    beat_t stall_b;
    always @(negedge clk) begin
        beat_t e;
        bit pop_now;
        if (!rst_n) begin
            issued    = 0;
            delivered = 0;
            stall_v   = 1'b0;
        end else begin
            pop_now = rvalid && rready;
            if (arready) chk("idle_quiet", {30'd0, mem_en, rvalid}, 32'd0);
            if (stall_v) chk("stall_hold", {10'd0, rvalid, rdata, rid, rlast}, {10'd0, 1'b1, stall_b});
            if (mem_en) begin
                chk("fifo_room", {31'd0, (issued - delivered - int'(pop_now)) < 2}, 32'd1);
                chk("mem_en_expected", {31'd0, exp_addr_q.size() != 0}, 32'd1);
                if (exp_addr_q.size() != 0) chk("mem_addr", {20'd0, mem_addr}, {20'd0, exp_addr_q.pop_front()});
                issued++;
            end
            if (pop_now) begin
                chk("beat_expected", {31'd0, exp_beat_q.size() != 0}, 32'd1);
                chk("rresp", {30'd0, rresp}, 32'd0);
                if (exp_beat_q.size() != 0) begin
                    e = exp_beat_q.pop_front();
                    chk("beat", {11'd0, rdata, rid, rlast}, {11'd0, e});
                end
                delivered++;
            end
            stall_v       = rvalid && !rready;
            stall_b.data  = rdata;
            stall_b.id    = rid;
            stall_b.last  = rlast;
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'h5A00;
        mem[8] = 16'hBEEF;
        rst_n = 1'b0; arvalid = 1'b0; rready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        mem_rdata = '0;

        // Reset state
        tick(); tick(); tick();
        rst_n = 1'b1;
        chk("rst_arready", {31'd0, arready}, 32'd1);
        chk("rst_quiet", {28'd0, rvalid, rlast, mem_en, |rresp}, 32'd0);
        chk("rst_rid_rdata", {12'd0, rid, rdata}, 32'd0);
        chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        tick();

        // Single beat with exact latency
        rready = 1'b1;
        do_ar(4'd3, 32'h10, 8'd0, 2'b01, 1'b0);
        chk("sb_t1_mem", {19'd0, mem_en, mem_addr}, {19'd0, 1'b1, 12'd8});
        tick();
        chk("sb_t2", {30'd0, rvalid, mem_en}, 32'd0);
        tick();
        chk("sb_t3_beat", {10'd0, rvalid, rdata, rid, rlast}, {10'd0, 1'b1, 16'hBEEF, 4'd3, 1'b1});
        chk("sb_t3_arready", {31'd0, arready}, 32'd0);
        tick();
        chk("sb_t4_arready", {31'd0, arready}, 32'd1);
        tick();

        // Full-rate 256-beat burst with a competing AR held valid
        do_ar(4'd5, 32'h0, 8'd255, 2'b01, 1'b1);
        arid = 4'd9; araddr = 32'h100; arlen = 8'd2;
        for (int i = 1; i <= 258; i++) begin
            chk("fr_arready", {31'd0, arready}, 32'd0);
            chk("fr_mem_en", {31'd0, mem_en}, {31'd0, i <= 256});
            if (i >= 3) chk("fr_rvalid", {31'd0, rvalid}, 32'd1);
            if (i == 258) begin
                chk("fr_rlast", {31'd0, rlast}, 32'd1);
                arvalid = 1'b0;
            end
            tick();
        end
        chk("fr_arready_back", {31'd0, arready}, 32'd1);
        tick();

        // Backpressure: toggling rready, then a long stall
        do_ar(4'd1, 32'h0, 8'd7, 2'b01, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rready = ~rready;
            tick();
        end
        rready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_stalled_valid", {31'd0, rvalid}, 32'd1);
        rready = 1'b1;
        wait_drain(40);
        tick();

        // FIXED burst: constant address, identical beats
        do_ar(4'd6, 32'h20, 8'd3, 2'b00, 1'b0);
        wait_drain(20);
        tick();

        // INCR burst wrapping across the top of memory
        do_ar(4'd7, 32'h1FFC, 8'd3, 2'b01, 1'b0);
        wait_drain(20);
        tick();

        // Reset during beat 5 of a 16-beat burst
        do_ar(4'd4, 32'h40, 8'd15, 2'b01, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("mr_beat5_valid", {27'd0, rvalid, rlast, rid}, {27'd0, 1'b1, 1'b0, 4'd4});
        rst_n = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        tick();
        rst_n = 1'b1;
        chk("mr_after_rst", {30'd0, rvalid, arready}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        do_ar(4'd2, 32'h50, 8'd1, 2'b01, 1'b0);
        wait_drain(20);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_read_slave.md
AXI_READ_SLAVE -- requirements
Module: axi_read_slave

Interface
REQ-001 Parameters SHALL be: ID_WIDTH, default 4, AXI ID width; ADDR_WIDTH, default 32, AXI byte-address width; DATA_WIDTH, default 16, read data width; MEM_AW, default 12, memory word-address width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- arid_s_inf  in  ID_WIDTH  read burst ID
- araddr_s_inf  in  ADDR_WIDTH  burst start byte address
- arlen_s_inf  in  8  beats minus 1
- arsize_s_inf  in  3  accepted, ignored
- arburst_s_inf  in  2  00 FIXED; any other value INCR
- arvalid_s_inf  in  1  address valid
- arready_s_inf  out  1  address ready
- rid_s_inf  out  ID_WIDTH  echo of latched arid
- rdata_s_inf  out  DATA_WIDTH  beat data
- rresp_s_inf  out  2  constant 2'b00 (OKAY)
- rlast_s_inf  out  1  final beat of burst
- rvalid_s_inf  out  1  beat valid
- rready_s_inf  in  1  master accepts beat
- mem_en  out  1  memory read strobe
- mem_addr  out  MEM_AW  memory word address
- mem_rdata  in  DATA_WIDTH  memory data, valid exactly 1 cycle after mem_en

Function
REQ-003 FSM SHALL have states IDLE and BURST.
- IDLE: arready=1.
- AR handshake (arvalid & arready) -> BURST; latch arid, arlen, arburst; word pointer = araddr[MEM_AW:1].
- BURST: arready=0. Leave to IDLE on the cycle after the rlast handshake (rvalid & rready & rlast).
REQ-004 One burst SHALL be outstanding at a time; arvalid during BURST SHALL be held off by arready=0.
REQ-005 Word pointer SHALL advance by 1 per issued mem_en for INCR, stay constant for FIXED, and wrap modulo 2^MEM_AW with no error.
REQ-006 Issue counter SHALL count mem_en strobes per burst. No mem_en SHALL issue once arlen+1 reads have issued. arlen=255 SHALL give 256 beats with no counter overflow.
REQ-007 Output buffer SHALL be a 2-entry FIFO feeding rdata/rvalid. mem_rdata SHALL be written to the FIFO the cycle after its mem_en.
REQ-008 mem_en SHALL assert in BURST only when (FIFO occupancy + in-flight read − pop this cycle) < 2. The FIFO SHALL never overflow, and no read data SHALL be dropped.
REQ-009 rvalid SHALL equal FIFO non-empty. rdata, rid and rlast SHALL be stable while rvalid=1 and rready=0.
REQ-010 rlast SHALL be 1 only on beat index arlen, counted by a delivered-beat counter.
REQ-011 Latency SHALL be: AR handshake in cycle T -> mem_en in T+1 -> first rvalid in T+3. With rready held high, one beat SHALL be delivered per cycle, rlast in T+3+arlen, and arready=1 again in T+4+arlen.
REQ-012 rready deasserted SHALL stall delivery. Issue SHALL resume the cycle after FIFO space frees, and the next beat SHALL follow the freed slot with no bubble.
REQ-013 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-014 In IDLE, rvalid and mem_en SHALL be 0.

Reset
REQ-015 When rst_n=0 at a clock edge, the block SHALL reset as follows:
- state IDLE; FIFO and all counters cleared; in-flight read discarded.
- arready=1 on the first cycle after reset release.
- rvalid=0, rlast=0, mem_en=0, rresp=0, rid=0, rdata=0, mem_addr=0.
REQ-016 Reset mid-burst SHALL abort the burst. No further beats of that burst SHALL appear after reset release.

Verification
REQ-017 Single beat: AR araddr=0x10, arlen=0, arid=3, memory word 8 = 0xBEEF, rready=1 -> mem_en with mem_addr=8 at T+1; rvalid, rdata=0xBEEF, rid=3, rlast=1 at T+3; arready=1 at T+4.
REQ-018 Full-rate burst: araddr=0, arlen=255, INCR, rready=1 -> mem_addr 0..255, one per cycle; 256 consecutive beats; rlast only on beat 255; arvalid held meanwhile gets arready=0 throughout.
REQ-019 Backpressure: arlen=7, rready toggles 1/0 each cycle then held 0 for 5 cycles -> no beat lost or duplicated; data order 0..7; rdata held stable while stalled; mem_en never asserted with FIFO full.
REQ-020 FIXED and wrap: arburst=00, arlen=3 -> mem_addr constant, 4 identical beats. INCR starting at word 4094 (MEM_AW=12), arlen=3 -> mem_addr 4094, 4095, 0, 1.
REQ-021 Reset mid-burst: rst_n=0 for 1 cycle during beat 5 of a 16-beat burst -> rvalid=0 the following cycle; arready=1 after release; next burst arlen=1 returns exactly 2 correct beats.
